// File: rtl/fetch_sequencer_pkg.sv
// Shared types and sizing for the instruction-fetch sequencer.
// Latency: n/a (definitions only); backpressure: n/a.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT,
        FAULT
    } state_e;

    localparam int PC_ADDR_W    = 12;
    localparam int MAX_WAIT_DEF = 15;

    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_WAIT_DEF);

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles PC control, imem req/ack and decode valid/ready signals of the sequencer.
// Latency: n/a (wiring only); backpressure: carried by imem_ack and ir_ready.
interface fetch_sequencer_if #(
    parameter int N       = 17,
    parameter int INSTR_W = 17
);
    import fetch_sequencer_pkg::*;

    logic                 start;
    logic                 halt_req;
    logic [PC_ADDR_W-1:0] pc_value;
    logic                 pc_write_en;
    logic                 pc_inc_en;
    logic                 pc_clr_en;
    logic [N-1:0]         pc_datain;
    logic                 imem_req;
    logic [PC_ADDR_W-1:0] imem_addr;
    logic                 imem_ack;
    logic [INSTR_W-1:0]   imem_rdata;
    logic [INSTR_W-1:0]   ir_out;
    logic                 ir_valid;
    logic                 ir_ready;
    logic                 branch_valid;
    logic [N-1:0]         branch_target;
    logic                 busy;
    logic                 fault;

    modport master (
        input  start, halt_req, pc_value, imem_ack, imem_rdata,
               ir_ready, branch_valid, branch_target,
        output pc_write_en, pc_inc_en, pc_clr_en, pc_datain,
               imem_req, imem_addr, ir_out, ir_valid, busy, fault
    );

    modport slave (
        output start, halt_req, pc_value, imem_ack, imem_rdata,
               ir_ready, branch_valid, branch_target,
        input  pc_write_en, pc_inc_en, pc_clr_en, pc_datain,
               imem_req, imem_addr, ir_out, ir_valid, busy, fault
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Saturating fetch-wait counter; expired is high during the MAX_WAIT-th enabled cycle.
// Latency: expired is combinational from the count; backpressure: none.
module fetch_timeout_ctr
    import fetch_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = cnt_width(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(MAX_WAIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of already-completed wait cycles
    assign expired = en && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns PC controls, fetches over req/ack, issues to decode over valid/ready.
// Latency: ack -> ir_valid one cycle; backpressure: ir_ready=0 holds ISSUE, missing ack faults after MAX_WAIT.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int N        = 17,
    parameter int INSTR_W  = 17,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    state_e             state_q, state_d;
    logic               halt_q, halt_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               imem_req_q, imem_req_d;
    logic               ir_valid_q, ir_valid_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;

    logic               pc_write, pc_inc, pc_clr;
    logic [N-1:0]       pc_datain;
    logic               in_fetch;
    logic               expired;

    assign in_fetch = (state_q == FETCH);

    fetch_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_fetch || bus.imem_ack),
        .en      (in_fetch && !bus.imem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        ir_d      = ir_q;
        pc_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_clr    = 1'b0;
        pc_datain = '0;

        if (bus.halt_req && (state_q != IDLE) && (state_q != FAULT)) begin
            halt_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_clr  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // an ack in the final permitted cycle still wins over the timeout
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_inc  = 1'b1;
                    state_d = ISSUE;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            ISSUE: begin
                if (bus.branch_valid) begin
                    pc_write  = 1'b1;
                    pc_datain = bus.branch_target;
                    state_d   = halt_q ? HALT : FETCH;
                end else if (bus.ir_ready) begin
                    state_d   = halt_q ? HALT : FETCH;
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == HALT) && (state_q != HALT)) begin
            halt_d = 1'b0;
        end

        imem_req_d = (state_d == FETCH);
        ir_valid_d = (state_d == ISSUE);
        busy_d     = (state_d == FETCH) || (state_d == ISSUE);
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            halt_q     <= 1'b0;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    // PC strobes are combinational; gating with rst_n keeps them low while reset is held
    assign bus.pc_write_en = rst_n && pc_write;
    assign bus.pc_inc_en   = rst_n && pc_inc;
    assign bus.pc_clr_en   = rst_n && pc_clr;
    assign bus.pc_datain   = rst_n ? pc_datain : '0;
    assign bus.imem_addr   = in_fetch ? bus.pc_value : '0;

    assign bus.imem_req    = imem_req_q;
    assign bus.ir_out      = ir_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple external PC model.
// Latency/backpressure exercised through scripted imem_ack and ir_ready patterns.
module tb_fetch_sequencer;
    localparam int N  = 17;
    localparam int IW = 17;

    logic clk = 1'b0;
    logic rst_n;

    fetch_sequencer_if #(.N(N), .INSTR_W(IW)) bus ();

    fetch_sequencer #(
        .N        (N),
        .INSTR_W  (IW),
        .MAX_WAIT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // external program counter driven by the sequencer's strobes
    logic [11:0] pc_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)               pc_q <= 12'hA5A;
        else if (bus.pc_clr_en)   pc_q <= 12'h000;
        else if (bus.pc_write_en) pc_q <= bus.pc_datain[11:0];
        else if (bus.pc_inc_en)   pc_q <= pc_q + 12'h001;
    end
    assign bus.pc_value = pc_q;

    always @(negedge clk) begin
        check_eq("pc_ctrl_excl",
                 32'(($countones({bus.pc_write_en, bus.pc_inc_en, bus.pc_clr_en}) <= 1)), 32'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"},   32'(bus.imem_req),    32'd0);
        check_eq({tag, "_addr"},  32'(bus.imem_addr),   32'd0);
        check_eq({tag, "_irv"},   32'(bus.ir_valid),    32'd0);
        check_eq({tag, "_ir"},    32'(bus.ir_out),      32'd0);
        check_eq({tag, "_busy"},  32'(bus.busy),        32'd0);
        check_eq({tag, "_we"},    32'(bus.pc_write_en), 32'd0);
        check_eq({tag, "_inc"},   32'(bus.pc_inc_en),   32'd0);
        check_eq({tag, "_clr"},   32'(bus.pc_clr_en),   32'd0);
        check_eq({tag, "_din"},   32'(bus.pc_datain),   32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start         = 1'b1;
        bus.halt_req      = 1'b0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.ir_ready      = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;

        // reset with start held high: every output must still be 0
        cyc(); cyc();
        check_quiet("rst");
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        cyc();

        // start from IDLE, ack one cycle after the request
        bus.start = 1'b1; #1;
        check_eq("idle_clr", 32'(bus.pc_clr_en), 32'd1);
        cyc();
        bus.start = 1'b0; #1;
        check_eq("f1_req",  32'(bus.imem_req),  32'd1);
        check_eq("f1_addr", 32'(bus.imem_addr), 32'h000);
        check_eq("f1_clr",  32'(bus.pc_clr_en), 32'd0);
        check_eq("f1_inc",  32'(bus.pc_inc_en), 32'd0);
        cyc();
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h1ABCD; #1;
        check_eq("f1_ack_inc", 32'(bus.pc_inc_en), 32'd1);
        cyc();
        bus.imem_ack = 1'b0; #1;
        check_eq("i1_valid", 32'(bus.ir_valid),  32'd1);
        check_eq("i1_ir",    32'(bus.ir_out),    32'h1ABCD);
        check_eq("i1_req",   32'(bus.imem_req),  32'd0);
        check_eq("i1_inc",   32'(bus.pc_inc_en), 32'd0);
        check_eq("i1_pc",    32'(bus.pc_value),  32'h001);

        // decode stalls for 5 cycles
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_eq("stall_valid", 32'(bus.ir_valid), 32'd1);
            check_eq("stall_ir",    32'(bus.ir_out),   32'h1ABCD);
            check_eq("stall_req",   32'(bus.imem_req), 32'd0);
            check_eq("stall_ctrl",  32'({bus.pc_write_en, bus.pc_inc_en, bus.pc_clr_en}), 32'd0);
        end
        bus.ir_ready = 1'b1; #1;
        cyc();
        bus.ir_ready = 1'b0; #1;
        check_eq("f2_req",  32'(bus.imem_req),  32'd1);
        check_eq("f2_addr", 32'(bus.imem_addr), 32'h001);
        check_eq("f2_irv",  32'(bus.ir_valid),  32'd0);

        // branch redirect from ISSUE
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h00111; #1;
        cyc();
        bus.imem_ack = 1'b0;
        bus.branch_valid = 1'b1; bus.branch_target = 17'h00345; #1;
        check_eq("br_we",  32'(bus.pc_write_en), 32'd1);
        check_eq("br_din", 32'(bus.pc_datain),   32'h00345);
        check_eq("br_inc", 32'(bus.pc_inc_en),   32'd0);
        cyc();
        bus.branch_valid = 1'b0; #1;
        check_eq("br_we_off", 32'(bus.pc_write_en), 32'd0);
        check_eq("br_req",    32'(bus.imem_req),    32'd1);
        check_eq("br_addr",   32'(bus.imem_addr),   32'h345);

        // halt request during FETCH, stop after the next handshake, resume
        bus.halt_req = 1'b1; #1;
        cyc();
        bus.halt_req = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h00AAA; #1;
        cyc();
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b1; #1;
        cyc();
        bus.ir_ready = 1'b0; #1;
        check_eq("halt_busy", 32'(bus.busy),      32'd0);
        check_eq("halt_req",  32'(bus.imem_req),  32'd0);
        check_eq("halt_irv",  32'(bus.ir_valid),  32'd0);
        check_eq("halt_addr", 32'(bus.imem_addr), 32'h000);
        cyc();
        check_eq("halt_hold", 32'(bus.busy), 32'd0);
        bus.start = 1'b1; #1;
        check_eq("resume_clr", 32'(bus.pc_clr_en), 32'd0);
        cyc();
        bus.start = 1'b0; #1;
        check_eq("resume_req",  32'(bus.imem_req),  32'd1);
        check_eq("resume_addr", 32'(bus.imem_addr), 32'h346);
        check_eq("resume_busy", 32'(bus.busy),      32'd1);

        // PC wrap: fetch at 0xFFF, next fetch at 0x000
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h00F0F; #1;
        cyc();
        bus.imem_ack = 1'b0;
        bus.branch_valid = 1'b1; bus.branch_target = 17'h00FFF; #1;
        cyc();
        bus.branch_valid = 1'b0; #1;
        check_eq("wrap_addr_fff", 32'(bus.imem_addr), 32'hFFF);
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h10001; #1;
        check_eq("wrap_inc", 32'(bus.pc_inc_en), 32'd1);
        cyc();
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b1; #1;
        cyc();
        bus.ir_ready = 1'b0; #1;
        check_eq("wrap_req",      32'(bus.imem_req),  32'd1);
        check_eq("wrap_addr_000", 32'(bus.imem_addr), 32'h000);

        // no ack for MAX_WAIT cycles -> FAULT
        for (int k = 1; k <= 15; k++) begin
            check_eq("to_req",   32'(bus.imem_req), 32'd1);
            check_eq("to_fault", 32'(bus.fault),    32'd0);
            cyc();
        end
        check_eq("fault_set",  32'(bus.fault),    32'd1);
        check_eq("fault_req",  32'(bus.imem_req), 32'd0);
        check_eq("fault_busy", 32'(bus.busy),     32'd0);
        bus.start = 1'b1; #1;
        check_eq("fault_noclr", 32'(bus.pc_clr_en), 32'd0);
        cyc();
        bus.start = 1'b0; #1;
        check_eq("fault_sticky", 32'(bus.fault),    32'd1);
        check_eq("fault_noreq",  32'(bus.imem_req), 32'd0);

        // only reset leaves FAULT; then ack exactly on the 15th cycle
        rst_n = 1'b0; #1;
        check_eq("rst_fault_clr", 32'(bus.fault), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.start = 1'b1; #1;
        cyc();
        bus.start = 1'b0;
        for (int k = 1; k < 15; k++) cyc();
        check_eq("late_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h0BEEF; #1;
        check_eq("late_inc", 32'(bus.pc_inc_en), 32'd1);
        cyc();
        bus.imem_ack = 1'b0; #1;
        check_eq("late_irv",   32'(bus.ir_valid), 32'd1);
        check_eq("late_ir",    32'(bus.ir_out),   32'h0BEEF);
        check_eq("late_fault", 32'(bus.fault),    32'd0);

        // reset asserted mid-FETCH; a late ack in IDLE is ignored
        bus.ir_ready = 1'b1; #1;
        cyc();
        bus.ir_ready = 1'b0; #1;
        check_eq("mid_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0; #1;
        check_quiet("midrst");
        bus.imem_ack = 1'b1; bus.imem_rdata = 17'h1FFFF;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        check_quiet("late_ack");
        check_eq("late_ack_fault", 32'(bus.fault), 32'd0);
        bus.imem_ack = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
